// File: rtl/rtc_bus_pkg.sv
// -----------------------------------------------------------------------------
// rtc_bus_pkg
// Shared definitions for the RTC multiplexed-bus cycle generator:
//   - bus-cycle state encoding (localparams plus the enum built on them)
//   - default setup / strobe / hold phase lengths
//   - RTC register address map
//   - max3() helper used to size the phase counter
// -----------------------------------------------------------------------------
package rtc_bus_pkg;

    // State encoding
    localparam logic [2:0] ENC_IDLE  = 3'd0;
    localparam logic [2:0] ENC_A_SET = 3'd1;
    localparam logic [2:0] ENC_A_STB = 3'd2;
    localparam logic [2:0] ENC_A_HLD = 3'd3;
    localparam logic [2:0] ENC_D_SET = 3'd4;
    localparam logic [2:0] ENC_D_STB = 3'd5;
    localparam logic [2:0] ENC_D_HLD = 3'd6;
    localparam logic [2:0] ENC_DONE  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE  = ENC_IDLE,
        S_A_SET = ENC_A_SET,
        S_A_STB = ENC_A_STB,
        S_A_HLD = ENC_A_HLD,
        S_D_SET = ENC_D_SET,
        S_D_STB = ENC_D_STB,
        S_D_HLD = ENC_D_HLD,
        S_DONE  = ENC_DONE
    } state_e;

    // Default phase lengths in clock cycles
    localparam int DEF_T_SU  = 2;
    localparam int DEF_T_PW  = 4;
    localparam int DEF_T_HLD = 2;

    // RTC register map
    localparam logic [7:0] REG_SECONDS = 8'h21;
    localparam logic [7:0] REG_MINUTES = 8'h22;
    localparam logic [7:0] REG_HOURS   = 8'h23;
    localparam logic [7:0] REG_DAY     = 8'h24;
    localparam logic [7:0] REG_MONTH   = 8'h25;
    localparam logic [7:0] REG_YEAR    = 8'h26;
    localparam logic [7:0] REG_CMD     = 8'hF0;
    localparam logic [7:0] REG_XFER    = 8'hF1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// -----------------------------------------------------------------------------
// rtc_phase_timer
// Loadable down-counter that times one bus-cycle phase. Loading value N makes
// `expired` rise N cycles later; the counter then rests at zero.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous, active-high reset (counter -> 0)
//   load     in   load `value` on this edge (takes priority over counting)
//   value    in   phase length minus one
//   expired  out  counter is zero: current cycle is the last of the phase
// -----------------------------------------------------------------------------
module rtc_phase_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             expired
);

    logic [WIDTH-1:0] r_count;

    // NOTE: sequential state is always updated with non-blocking assignments so
    // every register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= value;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign expired = (r_count == '0);

endmodule

// File: rtl/rtc_bus_cycle.sv
// -----------------------------------------------------------------------------
// rtc_bus_cycle
// Bus-cycle generator for the RTC multiplexed address/data port. Accepts one
// register transaction (command, address, data) and plays it out as an address
// phase followed by a data phase, each with setup / strobe / hold timing.
//
// Build option: define RTC_BUS_READ_EN to support read transactions. Without
// it every transaction is a write, `rd` never asserts, `rdata` is 0x00 and
// `ad_in` is ignored.
//
// Ports:
//   clk, reset      in   system clock, synchronous active-high reset
//   start           in   transaction request, honoured only when not busy
//   wr_op           in   1 = write, 0 = read
//   addr, wdata     in   register address and write data
//   busy            out  transaction in progress (address/data phases)
//   done            out  one-cycle completion pulse
//   rdata           out  last byte read
//   a_d             out  0 = address phase, 1 = data phase
//   cs, rd, wr      out  active-low chip strobes
//   ad_out, ad_oe   out  AD bus drive value and tri-state enable (1 = drive)
//   ad_in           in   AD bus sampled value
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module rtc_bus_cycle
    import rtc_bus_pkg::*;
#(
    parameter int T_SU  = DEF_T_SU,
    parameter int T_PW  = DEF_T_PW,
    parameter int T_HLD = DEF_T_HLD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       wr_op,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       a_d,
    output logic       cs,
    output logic       rd,
    output logic       wr,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in
);

    localparam int CW = $clog2(max3(T_SU, T_PW, T_HLD) + 1);
    localparam logic [CW-1:0] L_SU  = CW'(T_SU - 1);
    localparam logic [CW-1:0] L_PW  = CW'(T_PW - 1);
    localparam logic [CW-1:0] L_HLD = CW'(T_HLD - 1);

    state_e          r_state, w_state_n;
    logic [7:0]      r_addr, r_wdata;
    logic            w_capture;
    logic            w_load;
    logic [CW-1:0]   w_load_val;
    logic            w_expired;

    // Transaction fields as they will be seen in the next state; on a capture
    // edge these are the live inputs, otherwise the latched copies.
    logic [7:0]      w_addr_n, w_wdata_n;
    logic            w_is_read_n;

    // Next-cycle output values, registered below
    logic            w_busy, w_done, w_a_d, w_cs, w_rd, w_wr, w_ad_oe;
    logic [7:0]      w_ad_out;
    logic            r_busy, r_done, r_a_d, r_cs, r_rd, r_wr, r_ad_oe;
    logic [7:0]      r_ad_out;

    rtc_phase_timer #(.WIDTH(CW)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (w_load),
        .value   (w_load_val),
        .expired (w_expired)
    );

    // Next-state logic. Every timed state loads the counter for the state it
    // enters, so the counter always describes the current phase.
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_state_n  = r_state;
        w_capture  = 1'b0;
        w_load     = 1'b0;
        w_load_val = '0;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_n  = S_A_SET;
                    w_capture  = 1'b1;
                    w_load     = 1'b1;
                    w_load_val = L_SU;
                end else begin
                    w_state_n  = S_IDLE;
                end
            end
            S_A_SET: if (w_expired) begin
                w_state_n = S_A_STB; w_load = 1'b1; w_load_val = L_PW;
            end
            S_A_STB: if (w_expired) begin
                w_state_n = S_A_HLD; w_load = 1'b1; w_load_val = L_HLD;
            end
            S_A_HLD: if (w_expired) begin
                w_state_n = S_D_SET; w_load = 1'b1; w_load_val = L_SU;
            end
            S_D_SET: if (w_expired) begin
                w_state_n = S_D_STB; w_load = 1'b1; w_load_val = L_PW;
            end
            S_D_STB: if (w_expired) begin
                w_state_n = S_D_HLD; w_load = 1'b1; w_load_val = L_HLD;
            end
            S_D_HLD: if (w_expired) begin
                w_state_n = S_DONE;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    assign w_addr_n  = w_capture ? addr  : r_addr;
    assign w_wdata_n = w_capture ? wdata : r_wdata;

`ifdef RTC_BUS_READ_EN
    logic       r_is_read;
    logic [7:0] r_rdata;

    assign w_is_read_n = w_capture ? ~wr_op : r_is_read;

    // Read data is taken on the last strobe-low cycle of the data phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_is_read <= 1'b0;
            r_rdata   <= 8'h00;
        end else begin
            if (w_capture) begin
                r_is_read <= ~wr_op;
            end
            if (r_state == S_D_STB && w_expired && r_is_read) begin
                r_rdata <= ad_in;
            end
        end
    end

    assign rdata = r_rdata;
`else
    logic w_unused_read_inputs;

    assign w_is_read_n          = 1'b0;
    assign w_unused_read_inputs = ^{wr_op, ad_in};
    assign rdata                = 8'h00;
`endif

    // Output decode for the state about to be entered; registering it makes
    // the pins change on the same edge as the state.
    always_comb begin
        w_busy   = 1'b0;
        w_done   = 1'b0;
        w_a_d    = 1'b1;
        w_cs     = 1'b1;
        w_rd     = 1'b1;
        w_wr     = 1'b1;
        w_ad_oe  = 1'b0;
        w_ad_out = 8'h00;
        unique case (w_state_n)
            S_A_SET, S_A_STB, S_A_HLD: begin
                w_busy   = 1'b1;
                w_a_d    = 1'b0;
                w_ad_oe  = 1'b1;
                w_ad_out = w_addr_n;
                // The address is always latched into the chip with a write strobe.
                if (w_state_n == S_A_STB) begin
                    w_cs = 1'b0;
                    w_wr = 1'b0;
                end
            end
            S_D_SET, S_D_STB, S_D_HLD: begin
                w_busy = 1'b1;
                if (!w_is_read_n) begin
                    w_ad_oe  = 1'b1;
                    w_ad_out = w_wdata_n;
                end
                if (w_state_n == S_D_STB) begin
                    w_cs = 1'b0;
                    if (w_is_read_n) w_rd = 1'b0;
                    else             w_wr = 1'b0;
                end
            end
            S_DONE: w_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_addr   <= 8'h00;
            r_wdata  <= 8'h00;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_a_d    <= 1'b1;
            r_cs     <= 1'b1;
            r_rd     <= 1'b1;
            r_wr     <= 1'b1;
            r_ad_oe  <= 1'b0;
            r_ad_out <= 8'h00;
        end else begin
            r_state  <= w_state_n;
            r_addr   <= w_addr_n;
            r_wdata  <= w_wdata_n;
            r_busy   <= w_busy;
            r_done   <= w_done;
            r_a_d    <= w_a_d;
            r_cs     <= w_cs;
            r_rd     <= w_rd;
            r_wr     <= w_wr;
            r_ad_oe  <= w_ad_oe;
            r_ad_out <= w_ad_out;
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign a_d    = r_a_d;
    assign cs     = r_cs;
    assign rd     = r_rd;
    assign wr     = r_wr;
    assign ad_oe  = r_ad_oe;
    assign ad_out = r_ad_out;

endmodule

// File: tb/tb_rtc_bus_cycle.sv
// -----------------------------------------------------------------------------
// tb_rtc_bus_cycle
// Self-checking bench for rtc_bus_cycle with default timing. A transaction
// model tracks, per cycle, the offset since the accepting edge and derives the
// expected pins from the phase lengths; a compare process checks every cycle.
// Directed scenarios add literal expectations; a random phase follows.
// Honours RTC_BUS_READ_EN the same way the design does.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rtc_bus_cycle;

    localparam int T_SU  = 2;
    localparam int T_PW  = 4;
    localparam int T_HLD = 2;
    localparam int S     = T_SU + T_PW + T_HLD;  // cycles per phase
    localparam int L     = 2 * S + 1;            // offset of the done cycle
`ifdef RTC_BUS_READ_EN
    localparam bit READ_EN = 1'b1;
`else
    localparam bit READ_EN = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       wr_op = 1'b1;
    logic [7:0] addr  = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic [7:0] ad_in = 8'h00;
    logic       busy, done, a_d, cs, rd, wr, ad_oe;
    logic [7:0] rdata, ad_out;

    rtc_bus_cycle #(.T_SU(T_SU), .T_PW(T_PW), .T_HLD(T_HLD)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .wr_op  (wr_op),
        .addr   (addr),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .rdata  (rdata),
        .a_d    (a_d),
        .cs     (cs),
        .rd     (rd),
        .wr     (wr),
        .ad_out (ad_out),
        .ad_oe  (ad_oe),
        .ad_in  (ad_in)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_bad  = 0;
    int cyc    = 0;   // index of the current cycle; cycle n ends at edge n
    int n_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- transaction model ----------------
    int         m_acc   = -1;     // cycle whose closing edge accepted the txn
    logic [7:0] m_addr  = 8'h00;
    logic [7:0] m_wdata = 8'h00;
    logic [7:0] m_rdata = 8'h00;
    bit         m_rd    = 1'b0;
    bit         chk_en  = 1'b0;

    always @(posedge clk) begin
        int k;
        k = (m_acc < 0) ? 0 : cyc - m_acc;
        if (reset) begin
            m_acc   = -1;
            m_rdata = 8'h00;
            chk_en  = 1'b1;
        end else begin
            if (m_acc >= 0 && m_rd && k == S + T_SU + T_PW) m_rdata = ad_in;
            if ((m_acc < 0 || k >= L) && start) begin
                m_acc   = cyc;
                m_addr  = addr;
                m_wdata = wdata;
                m_rd    = READ_EN && !wr_op;
            end else if (k >= L) begin
                m_acc = -1;
            end
        end
        cyc++;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        int k, j;
        bit e_busy, e_done, e_ad, e_cs, e_rd, e_wr, e_oe, dph, stb;
        logic [7:0] e_out;
        if (chk_en) begin
            k      = (m_acc < 0) ? 0 : cyc - m_acc;
            e_busy = (k >= 1 && k < L);
            e_done = (k == L);
            e_ad = 1'b1; e_cs = 1'b1; e_rd = 1'b1; e_wr = 1'b1; e_oe = 1'b0; e_out = 8'h00;
            if (e_busy) begin
                dph   = (k > S);
                j     = dph ? k - S : k;
                stb   = (j > T_SU && j <= T_SU + T_PW);
                e_ad  = dph;
                e_cs  = !stb;
                e_rd  = !(stb && dph && m_rd);
                e_wr  = !(stb && !(dph && m_rd));
                e_oe  = !(dph && m_rd);
                e_out = dph ? m_wdata : m_addr;
            end
            check("busy", busy, e_busy);
            check("done", done, e_done);
            check("a_d", a_d, e_ad);
            check("cs", cs, e_cs);
            check("rd", rd, e_rd);
            check("wr", wr, e_wr);
            check("ad_oe", ad_oe, e_oe);
            if (e_oe || !e_busy) check("ad_out", ad_out, e_out);
            check("rdata", rdata, m_rdata);
            check("rd_wr_exclusive", rd | wr, 1'b1);
            if (done === 1'b1) n_done++;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance to cycle n (bounded) and stop at its falling edge.
    task automatic go_to(input int n);
        for (int g = 0; g < 200 && cyc < n; g++) step();
        @(negedge clk);
    endtask

    task automatic launch(input bit w, input logic [7:0] a, input logic [7:0] d, output int t0);
        t0    = cyc;
        start = 1'b1;
        wr_op = w;
        addr  = a;
        wdata = d;
        step();
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, d0;
        repeat (3) step();
        reset = 1'b0;
        go_to(cyc + 2);
        check("reset_a_d", a_d, 1'b1);
        check("reset_ad_oe", ad_oe, 1'b0);

        // Write 0x45 to seconds register
        launch(1'b1, 8'h21, 8'h45, t0);
        go_to(t0 + 1);  check("w_c1_a_d", a_d, 1'b0); check("w_c1_ad_out", ad_out, 8'h21);
        go_to(t0 + 3);  check("w_c3_cs", cs, 1'b0);   check("w_c3_wr", wr, 1'b0);
        go_to(t0 + 8);  check("w_c8_a_d", a_d, 1'b0); check("w_c8_ad_out", ad_out, 8'h21);
        go_to(t0 + 9);  check("w_c9_a_d", a_d, 1'b1);
        go_to(t0 + 11); check("w_c11_wr", wr, 1'b0);  check("w_c11_ad_out", ad_out, 8'h45);
        go_to(t0 + 14); check("w_c14_cs", cs, 1'b0);
        go_to(t0 + 15); check("w_c15_wr", wr, 1'b1);
        go_to(t0 + 16); check("w_c16_done", done, 1'b0);
        go_to(t0 + 17); check("w_c17_done", done, 1'b1); check("w_c17_busy", busy, 1'b0);
        go_to(t0 + 18); check("w_c18_done", done, 1'b0);

        // Read of minutes register, chip returns 0x59
        launch(1'b0, 8'h22, 8'h00, t0);
        ad_in = 8'h59;
        go_to(t0 + 12);
`ifdef RTC_BUS_READ_EN
        check("r_c12_ad_oe", ad_oe, 1'b0);
        check("r_c12_rd", rd, 1'b0);
        check("r_c12_wr", wr, 1'b1);
        go_to(t0 + 17); check("r_c17_rdata", rdata, 8'h59);
`else
        check("r_c12_rd", rd, 1'b1);
        check("r_c12_wr", wr, 1'b0);
        go_to(t0 + 17); check("r_c17_rdata", rdata, 8'h00);
`endif
        go_to(t0 + 19);

        // Start while busy is ignored
        d0 = n_done;
        launch(1'b1, 8'h21, 8'h11, t0);
        go_to(t0 + 5);
        start = 1'b1; addr = 8'h23;
        step();
        start = 1'b0;
        go_to(t0 + 7); check("ign_c7_ad_out", ad_out, 8'h21);
        go_to(t0 + L + 4); check("ign_done_count", n_done - d0, 1);

        // Start held through DONE: back-to-back transaction
        launch(1'b1, 8'h21, 8'h22, t0);
        go_to(t0 + 16);
        start = 1'b1; addr = 8'h24; wdata = 8'h66; wr_op = 1'b1;
        go_to(t0 + 18);
        start = 1'b0;
        check("b2b_c18_ad_out", ad_out, 8'h24);
        check("b2b_c18_busy", busy, 1'b1);
        go_to(t0 + 17 + L + 2);

        // Reset in the middle of a write
        launch(1'b1, 8'h25, 8'h77, t0);
        go_to(t0 + 5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        d0 = n_done;
        go_to(t0 + 6);
        check("rst_c6_busy", busy, 1'b0);
        check("rst_c6_cs", cs, 1'b1);
        check("rst_c6_ad_oe", ad_oe, 1'b0);
        go_to(t0 + 46); check("rst_no_done", n_done - d0, 0);

        // Random traffic, occasional reset
        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(0, 3) == 0);
            wr_op = $urandom_range(0, 1);
            addr  = 8'($urandom);
            wdata = 8'($urandom);
            ad_in = 8'($urandom);
            reset = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;
        start = 1'b0;
        repeat (L + 2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rtc_bus_cycle.md
# rtc_bus_cycle

Bus-cycle generator for the RTC's multiplexed address/data port. It accepts one register transaction from the write or read FSM: a command, address and data byte. It then drives the chip's `a_d`, `cs`, `rd`, `wr` and the shared AD[7:0] bus with programmable setup, pulse and hold times. The block sits directly downstream of the RTC write FSM and its read counterpart, between them and the FPGA pins.

## Interface
Parameters:
- `T_SU`, 2: setup cycles per phase (≥1)
- `T_PW`, 4: strobe-low cycles per phase (≥1)
- `T_HLD`, 2: hold cycles per phase (≥1)

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  transaction request; sampled only when `busy`=0
- `wr_op`  in  1  1 = write, 0 = read
- `addr`  in  8  RTC register address
- `wdata`  in  8  write data
- `busy`  out  1  transaction in progress
- `done`  out  1  one-cycle completion pulse
- `rdata`  out  8  last byte read
- `a_d`  out  1  0 = address phase, 1 = data phase
- `cs`, `rd`, `wr`  out  1 each  active-low chip strobes
- `ad_out`  out  8  AD bus drive value
- `ad_oe`  out  1  AD tri-state enable; 1 = FPGA drives
- `ad_in`  in  8  AD bus sampled value

## Operation
- Reset values: `a_d`=1, `cs`=`rd`=`wr`=1, `ad_oe`=0, `ad_out`=0x00, `busy`=0, `done`=0, `rdata`=0x00, state IDLE.
- The block captures `start` in IDLE or DONE. On capture it latches `addr`, `wdata` and `wr_op`, then goes to A_SET. Later changes to the inputs have no effect.
- States, each held for its count and then advancing:
  - A_SET (T_SU): `a_d`=0, `ad_oe`=1, `ad_out`=addr, strobes high.
  - A_STB (T_PW): as A_SET, plus `cs`=0 and `wr`=0. The address is always written.
  - A_HLD (T_HLD): strobes high, address still driven.
  - D_SET (T_SU): `a_d`=1. Write: `ad_out`=data, `ad_oe`=1. Read: `ad_oe`=0.
  - D_STB (T_PW): `cs`=0, plus `wr`=0 for a write or `rd`=0 for a read.
  - D_HLD (T_HLD): strobes high, drive unchanged.
  - DONE (1 cycle): `done`=1, bus returns to reset values. Next state is A_SET if `start`=1, else IDLE.
- Read capture: `rdata` <= `ad_in` on the last cycle of D_STB. `rdata` holds until the next completed read; writes never alter it.
- `busy`=1 in A_SET..D_HLD and 0 in IDLE/DONE. `start` while `busy`=1 is ignored (no queue).
- Never `rd`=0 and `wr`=0 together. `ad_oe`=1 never coincides with `rd`=0.
- Phase counter: down-counter loaded with count−1 on state entry; the state advances when it reaches 0. Width is $clog2(max(T_SU,T_PW,T_HLD)+1).
- Reset asserted mid-transaction: next edge gives reset values; the transaction is dropped and `done` is not pulsed.

## Timing
- `start` sampled at edge 0. A_SET begins at cycle 1.
- `done`=1 in cycle 2·(T_SU+T_PW+T_HLD)+1. With defaults this is cycle 17.
- Back-to-back: `start` accepted during DONE puts A_SET in the next cycle. Throughput is one transaction per 2·(T_SU+T_PW+T_HLD)+1 cycles.
- All outputs are registered with no combinational path from inputs to outputs. `rdata` is valid in the DONE cycle.

## Configuration
- `RTC_BUS_READ_EN`
  - Defined: read transactions are supported as described.
  - Undefined: `wr_op` is ignored and every transaction is a write. `rd` is tied 1, `rdata` is tied 0x00, and `ad_in` is unused.

## Structure
- Package `rtc_bus_pkg` holds:
  - State encoding localparams (IDLE, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD, DONE).
  - Default T_SU/T_PW/T_HLD.
  - RTC register addresses: seconds 0x21, minutes 0x22, hours 0x23, day 0x24, month 0x25, year 0x26, command/transfer 0xF0/0xF1.
- Sub-module `rtc_phase_timer`: loadable down-counter with `load`, `value` and `expired`.

## Test plan
- Write addr 0x21, data 0x45, defaults:
  - `a_d`=0 in cycles 1–8 with `ad_out`=0x21.
  - `cs`/`wr` low in cycles 3–6 and 11–14, with `ad_out`=0x45 during cycles 11–14.
  - `done` at cycle 17.
- Read addr 0x22 with `ad_in`=0x59: `ad_oe`=0 in cycles 9–16, `rd` low in cycles 11–14, `wr` high throughout the data phase, `rdata`=0x59 at `done`.
- `start` pulsed at cycle 5 with addr 0x23: ignored, bus still shows 0x21, exactly one `done`.
- `start` held through DONE with addr 0x24: second A_SET immediately follows, `ad_out`=0x24 at cycle 18.
- `reset` at cycle 5 of a write: all outputs at reset values from cycle 6, and no `done` within 40 cycles.
- Macro undefined, read request with `wr_op`=0: `wr` strobes in the data phase, `rd` stays 1, `rdata` stays 0x00.
